// File: rtl/ev22_sequencer.sv
// rtl/ev22_sequencer.sv - EV22 microinstruction sequencer: fetch, bank/ALU control, jumps, halt/resume
module ev22_sequencer #(
  parameter int          PC_W      = 10,
  parameter logic [5:0]  NOWR_CODE = 6'd35
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [47:0]     imem_data,
  input  logic            alu_z,
  input  logic            alu_c,
  output logic [4:0]      sel_a,
  output logic [5:0]      sel_b,
  output logic [5:0]      sel_c,
  output logic            c_we,
  output logic [3:0]      aluc,
  output logic            kmux,
  output logic [15:0]     k,
  output logic            mr,
  output logic            mw,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [3:0]      ir_jcond;
  logic [5:0]      ir_sel_c;
  logic            z_q;
  logic            c_q;
  logic            taken;
  logic            halt_op;
  logic [PC_W-1:0] pc_next;
  logic            unused_reserved;

  assign imem_addr       = pc;
  assign unused_reserved = ^imem_data[19:16];

  // Jump decision uses the flags captured at the end of this instruction's EXEC cycle.
  always_comb begin
    taken   = 1'b0;
    halt_op = 1'b0;
    case (ir_jcond)
      4'd1:    taken   = 1'b1;
      4'd2:    taken   = z_q;
      4'd3:    taken   = ~z_q;
      4'd4:    taken   = c_q;
      4'd5:    taken   = ~c_q;
      4'd6:    halt_op = 1'b1;
      default: taken   = 1'b0;
    endcase
  end

  assign pc_next = taken ? k[PC_W-1:0] : pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_START;
      pc       <= '0;
      ir_jcond <= 4'd0;
      ir_sel_c <= NOWR_CODE;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      imem_req <= 1'b0;
      sel_a    <= 5'd0;
      sel_b    <= 6'd0;
      sel_c    <= NOWR_CODE;
      c_we     <= 1'b0;
      aluc     <= 4'd0;
      kmux     <= 1'b0;
      k        <= 16'd0;
      mr       <= 1'b0;
      mw       <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            ir_jcond <= imem_data[43:40];
            ir_sel_c <= imem_data[25:20];
            aluc     <= imem_data[47:44];
            kmux     <= imem_data[39];
            mr       <= imem_data[38];
            mw       <= imem_data[37];
            sel_a    <= imem_data[36:32];
            sel_b    <= imem_data[31:26];
            k        <= imem_data[15:0];
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          z_q   <= alu_z;
          c_q   <= alu_c;
          sel_c <= ir_sel_c;
          c_we  <= (ir_sel_c != NOWR_CODE);
          state <= S_WB;
        end
        S_WB: begin
          pc    <= pc_next;
          mr    <= 1'b0;
          mw    <= 1'b0;
          c_we  <= 1'b0;
          sel_c <= NOWR_CODE;
          if (halt_op) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          if (run) begin
            halted   <= 1'b0;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule
